// File: rtl/decoder_scan_seq_if.sv
// Control and decoded-output bundle for decoder_scan_seq.
// The master supplies enable/mode/select/dwell; the slave returns the registered decode.
interface decoder_scan_seq_if #(
    parameter int SEL_W   = 2,
    parameter int DWELL_W = 8
);
    localparam int OUT_W = 2 ** SEL_W;

    logic               en;
    logic               mode;
    logic [SEL_W-1:0]   sel;
    logic [DWELL_W-1:0] dwell;
    logic [OUT_W-1:0]   out;
    logic [SEL_W-1:0]   idx;
    logic               wrap;

    modport master (
        output en, mode, sel, dwell,
        input  out, idx, wrap
    );

    modport slave (
        input  en, mode, sel, dwell,
        output out, idx, wrap
    );
endinterface

// File: rtl/decoder_scan_seq.sv
// Registered one-hot decoder (MSB-first) with DIRECT decode and an auto-scan mode
// that rotates the active line, holding each position for dwell+1 cycles.
module decoder_scan_seq #(
    parameter int SEL_W   = 2,
    parameter int DWELL_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    decoder_scan_seq_if.slave bus
);
    localparam int OUT_W = 2 ** SEL_W;

    typedef enum logic [1:0] {
        OFF,
        DIRECT,
        SCAN
    } state_t;

    state_t             state;
    logic [DWELL_W-1:0] cnt;
    logic [OUT_W-1:0]   out_q;
    logic [SEL_W-1:0]   idx_q;
    logic               wrap_q;
    logic [SEL_W-1:0]   idx_next;

    // Index k lights out[OUT_W-1-k], so index 0 drives the MSB.
    function automatic logic [OUT_W-1:0] onehot(input logic [SEL_W-1:0] k);
        logic [OUT_W-1:0] v;
        for (int i = 0; i < OUT_W; i++) begin
            v[i] = (k == SEL_W'(OUT_W - 1 - i));
        end
        return v;
    endfunction

    assign idx_next = idx_q + 1'b1;

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= OFF;
            out_q  <= '0;
            idx_q  <= '0;
            wrap_q <= 1'b0;
            cnt    <= '0;
        end else begin
            wrap_q <= 1'b0;
            if (!bus.en) begin
                // idx deliberately holds so software can see where output stopped.
                state <= OFF;
                out_q <= '0;
                cnt   <= '0;
            end else if (!bus.mode) begin
                state <= DIRECT;
                idx_q <= bus.sel;
                out_q <= onehot(bus.sel);
                cnt   <= '0;
            end else begin
                state <= SCAN;
                if (state != SCAN) begin
                    idx_q <= bus.sel;
                    out_q <= onehot(bus.sel);
                    cnt   <= '0;
                end else if (cnt >= bus.dwell) begin
                    // >= rather than == so a dwell lowered mid-slot advances at once.
                    cnt    <= '0;
                    idx_q  <= idx_next;
                    out_q  <= onehot(idx_next);
                    wrap_q <= &idx_q;
                end else begin
                    cnt <= cnt + 1'b1;
                end
            end
        end
    end

    assign bus.out  = out_q;
    assign bus.idx  = idx_q;
    assign bus.wrap = wrap_q;
endmodule

// File: tb/tb_decoder_scan_seq.sv
// Directed bench for decoder_scan_seq: SEL_W=2/DWELL_W=8 and SEL_W=3/DWELL_W=4 instances
// driven step by step, expectations queued at drive time and popped after each edge.
module tb_decoder_scan_seq;
    logic clk;
    logic rsta;
    logic rstb;
    int   checks = 0;
    int   errors = 0;

    typedef struct {
        logic [7:0] out;
        logic [2:0] idx;
        logic       wrap;
        string      tag;
    } exp_t;

    exp_t sb[$];

    decoder_scan_seq_if #(.SEL_W(2), .DWELL_W(8)) ifa ();
    decoder_scan_seq_if #(.SEL_W(3), .DWELL_W(4)) ifb ();

    decoder_scan_seq #(.SEL_W(2), .DWELL_W(8)) dut_a (.clk(clk), .rst(rsta), .bus(ifa));
    decoder_scan_seq #(.SEL_W(3), .DWELL_W(4)) dut_b (.clk(clk), .rst(rstb), .bus(ifb));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int oh(input int k, input int w);
        return 1 << (w - 1 - k);
    endfunction

    task automatic check_out(input logic [7:0] o, input logic [2:0] ix, input logic w);
        exp_t e;
        e = sb.pop_front();
        checks++;
        assert (o === e.out) else begin
            errors++;
            $error("FAIL %s out: got %b want %b", e.tag, o, e.out);
        end
        checks++;
        assert (ix === e.idx) else begin
            errors++;
            $error("FAIL %s idx: got %0d want %0d", e.tag, ix, e.idx);
        end
        checks++;
        assert (w === e.wrap) else begin
            errors++;
            $error("FAIL %s wrap: got %b want %b", e.tag, w, e.wrap);
        end
        checks++;
        assert ($onehot0(ifa.out) && $onehot0(ifb.out)) else begin
            errors++;
            $error("FAIL %s onehot0: got a=%b b=%b want at most one bit", e.tag, ifa.out, ifb.out);
        end
    endtask

    task automatic step_a(input logic r, input logic e, input logic m, input int s, input int d,
                          input int eo, input int ei, input logic ew, input string tag);
        rsta      = r;
        ifa.en    = e;
        ifa.mode  = m;
        ifa.sel   = 2'(s);
        ifa.dwell = 8'(d);
        sb.push_back('{out: 8'(eo), idx: 3'(ei), wrap: ew, tag: tag});
        @(posedge clk);
        #1;
        check_out(8'(ifa.out), 3'(ifa.idx), ifa.wrap);
    endtask

    task automatic step_b(input logic r, input logic e, input logic m, input int s, input int d,
                          input int eo, input int ei, input logic ew, input string tag);
        rstb      = r;
        ifb.en    = e;
        ifb.mode  = m;
        ifb.sel   = 3'(s);
        ifb.dwell = 4'(d);
        sb.push_back('{out: 8'(eo), idx: 3'(ei), wrap: ew, tag: tag});
        @(posedge clk);
        #1;
        check_out(ifb.out, ifb.idx, ifb.wrap);
    endtask

    initial begin
        int k;
        rsta = 1'b1; rstb = 1'b1;
        ifa.en = 1'b0; ifa.mode = 1'b0; ifa.sel = '0; ifa.dwell = '0;
        ifb.en = 1'b0; ifb.mode = 1'b0; ifb.sel = '0; ifb.dwell = '0;

        // Reset with arbitrary inputs, then disabled
        step_a(1, 1, 1, 3, 5, 'b0000, 0, 0, "a_rst0");
        step_a(1, 0, 0, 2, 0, 'b0000, 0, 0, "a_rst1");
        step_a(0, 0, 1, 1, 0, 'b0000, 0, 0, "a_off0");
        step_a(0, 0, 0, 3, 0, 'b0000, 0, 0, "a_off1");

        // DIRECT decode
        step_a(0, 1, 0, 0, 0, 'b1000, 0, 0, "a_dir0");
        step_a(0, 1, 0, 1, 0, 'b0100, 1, 0, "a_dir1");
        step_a(0, 1, 0, 2, 0, 'b0010, 2, 0, "a_dir2");
        step_a(0, 1, 0, 3, 0, 'b0001, 3, 0, "a_dir3");

        // SCAN from sel=2, dwell=2; sel changes after entry are ignored
        step_a(0, 1, 1, 2, 2, 'b0010, 2, 0, "a_scan_d2");
        for (int i = 1; i < 12; i++) begin
            k = (2 + i / 3) % 4;
            step_a(0, 1, 1, 0, 2, oh(k, 4), k, (i == 6), "a_scan_d2");
        end

        // Disabled: idx holds, then dwell=0 rotates every cycle
        step_a(0, 0, 1, 0, 0, 'b0000, 1, 0, "a_off_hold");
        for (int i = 0; i < 9; i++) begin
            k = i % 4;
            step_a(0, 1, 1, 0, 0, oh(k, 4), k, (i == 4 || i == 8), "a_scan_d0");
        end

        // One-cycle pause mid-scan, restart from sel=1 with a fresh slot
        step_a(0, 0, 1, 1, 2, 'b0000, 0, 0, "a_pause");
        for (int i = 0; i < 4; i++) begin
            k = (i < 3) ? 1 : 2;
            step_a(0, 1, 1, 1, 2, oh(k, 4), k, 0, "a_restart");
        end

        // Long dwell lowered to 0 mid-slot, reset mid-scan, mode switches
        step_a(0, 0, 1, 0, 0, 'b0000, 2, 0, "a_off2");
        for (int i = 0; i < 4; i++) step_a(0, 1, 1, 0, 200, 'b1000, 0, 0, "a_dw200");
        step_a(0, 1, 1, 0, 0, 'b0100, 1, 0, "a_dwdrop0");
        step_a(0, 1, 1, 0, 0, 'b0010, 2, 0, "a_dwdrop1");
        step_a(1, 1, 1, 2, 0, 'b0000, 0, 0, "a_rst_mid");
        step_a(0, 1, 1, 3, 0, 'b0001, 3, 0, "a_rescan");
        step_a(0, 1, 0, 2, 0, 'b0010, 2, 0, "a_scan2dir");
        step_a(0, 1, 1, 1, 5, 'b0100, 1, 0, "a_dir2scan");
        step_a(0, 1, 1, 3, 5, 'b0100, 1, 0, "a_sel_ign");

        // Wide variant: reset, DIRECT sweep
        step_b(1, 1, 1, 7, 9, 0, 0, 0, "b_rst0");
        step_b(1, 0, 0, 0, 0, 0, 0, 0, "b_rst1");
        for (int i = 0; i < 8; i++) step_b(0, 1, 0, i, 0, oh(i, 8), i, 0, "b_dir");

        // SCAN from 6 with dwell=2, wrapping 7->0
        for (int i = 0; i < 12; i++) begin
            k = (6 + i / 3) % 8;
            step_b(0, 1, 1, (i == 0) ? 6 : 3, 2, oh(k, 8), k, (i == 6), "b_scan_d2");
        end

        // dwell=0 full rotations
        step_b(0, 0, 1, 0, 0, 0, 1, 0, "b_off_hold");
        for (int i = 0; i < 17; i++) begin
            k = i % 8;
            step_b(0, 1, 1, 0, 0, oh(k, 8), k, (i == 8 || i == 16), "b_scan_d0");
        end

        // Maximum dwell: 16-cycle slot
        step_b(0, 0, 1, 5, 15, 0, 0, 0, "b_off2");
        for (int i = 0; i < 17; i++) begin
            k = (i < 16) ? 5 : 6;
            step_b(0, 1, 1, 5, 15, oh(k, 8), k, 0, "b_dwmax");
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
